// File: rtl/config_memory_unit.sv
// Configuration memory: captures a config word on a write_en rising edge, validates it,
// then commits it to the active settings (or rejects it) and exposes the committed fields.
module config_memory_unit #(
   parameter logic [7:0] TEMP_MIN  = 8'd10,
   parameter logic [7:0] TEMP_MAX  = 8'd35,
   parameter logic [7:0] LIGHT_MAX = 8'd100
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        write_en,
   input  logic [34:0] configin,
   output logic [1:0]  syskey,
   output logic        busy,
   output logic        write_done,
   output logic        write_err,
   output logic [7:0]  temp_set,
   output logic [7:0]  light_lvl,
   output logic [7:0]  alarm_delay,
   output logic [7:0]  dev_mask,
   output logic [7:0]  write_count,
   input  logic [1:0]  rd_sel,
   output logic [7:0]  rd_data
);

   typedef enum logic [1:0] {IDLE, CHECK, COMMIT, REJECT} state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [34:0] shadow_q, shadow_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [1:0]  syskey_q, syskey_d;
   logic [7:0]  temp_set_q, temp_set_d;
   logic [7:0]  light_lvl_q, light_lvl_d;
   logic [7:0]  alarm_delay_q, alarm_delay_d;
   logic [7:0]  dev_mask_q, dev_mask_d;
   logic [7:0]  write_count_q, write_count_d;
   logic [7:0]  rd_data_q, rd_data_d;

   logic [7:0] sh_temp, sh_light, sh_delay;
   logic       shadow_ok;

   assign sh_temp   = shadow_q[31:24];
   assign sh_light  = shadow_q[23:16];
   assign sh_delay  = shadow_q[15:8];
   assign shadow_ok = (sh_temp >= TEMP_MIN) && (sh_temp <= TEMP_MAX) &&
                      (sh_light <= LIGHT_MAX) && (sh_delay != 8'd0);

   always_comb begin
      state_d       = state_q;
      we_d          = write_en;
      shadow_d      = shadow_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      err_d         = 1'b0;
      syskey_d      = syskey_q;
      temp_set_d    = temp_set_q;
      light_lvl_d   = light_lvl_q;
      alarm_delay_d = alarm_delay_q;
      dev_mask_d    = dev_mask_q;
      write_count_d = write_count_q;

      case (state_q)
         IDLE: begin
            // Edges arriving in any other state are dropped, not queued.
            if (write_en && !we_q) begin
               shadow_d = configin;
               busy_d   = 1'b1;
               state_d  = CHECK;
            end
         end
         CHECK: state_d = shadow_ok ? COMMIT : REJECT;
         COMMIT: begin
            temp_set_d    = shadow_q[31:24];
            light_lvl_d   = shadow_q[23:16];
            alarm_delay_d = shadow_q[15:8];
            dev_mask_d    = shadow_q[7:0];
            if (shadow_q[34]) syskey_d = shadow_q[33:32];
            if (write_count_q != 8'hFF) write_count_d = write_count_q + 8'd1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         REJECT: begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      case (rd_sel)
         2'd0:    rd_data_d = temp_set_q;
         2'd1:    rd_data_d = light_lvl_q;
         2'd2:    rd_data_d = alarm_delay_q;
         default: rd_data_d = dev_mask_q;
      endcase
   end

   // we_q resets high so a write_en held through reset must drop before it can trigger.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q       <= IDLE;
         we_q          <= 1'b1;
         shadow_q      <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         syskey_q      <= 2'b00;
         temp_set_q    <= 8'd22;
         light_lvl_q   <= 8'd0;
         alarm_delay_q <= 8'd30;
         dev_mask_q    <= 8'd0;
         write_count_q <= 8'd0;
         rd_data_q     <= 8'd0;
      end else begin
         state_q       <= state_d;
         we_q          <= we_d;
         shadow_q      <= shadow_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_q         <= err_d;
         syskey_q      <= syskey_d;
         temp_set_q    <= temp_set_d;
         light_lvl_q   <= light_lvl_d;
         alarm_delay_q <= alarm_delay_d;
         dev_mask_q    <= dev_mask_d;
         write_count_q <= write_count_d;
         rd_data_q     <= rd_data_d;
      end
   end

   assign syskey      = syskey_q;
   assign busy        = busy_q;
   assign write_done  = done_q;
   assign write_err   = err_q;
   assign temp_set    = temp_set_q;
   assign light_lvl   = light_lvl_q;
   assign alarm_delay = alarm_delay_q;
   assign dev_mask    = dev_mask_q;
   assign write_count = write_count_q;
   assign rd_data     = rd_data_q;

endmodule

// File: doc/config_memory_unit.md
# config_memory_unit

Configuration memory at the far end of the smart-home control path. Accepts 35-bit configuration words that the control unit writes with `write_en`, validates them, and commits them to the active appliance settings. Supplies the current system key (`syskey`) back to the control unit's password check. Exposes the committed fields to the appliance drivers and through a registered readback port.

## Interface

Parameters:
- `TEMP_MIN`, 8'd10: lowest legal temperature setpoint.
- `TEMP_MAX`, 8'd35: highest legal temperature setpoint.
- `LIGHT_MAX`, 8'd100: highest legal light level.

Ports (reset arst, asynchronous, active-low; clock clk):
- `clk`  in  1  clock, rising edge.
- `arst`  in  1  asynchronous reset, active-low.
- `write_en`  in  1  write request level from control unit; may stay high for many cycles.
- `configin`  in  35  config word from control unit. Bit [34] key_change, [33:32] new_key, [31:24] temp, [23:16] light, [15:8] alarm_delay, [7:0] dev_mask.
- `syskey`  out  2  current system key to control unit.
- `busy`  out  1  high from capture until commit or reject completes.
- `write_done`  out  1  one-cycle pulse on successful commit.
- `write_err`  out  1  one-cycle pulse on rejected word.
- `temp_set`, `light_lvl`, `alarm_delay`, `dev_mask`  out  8 each  committed fields.
- `write_count`  out  8  number of successful commits, saturating.
- `rd_sel`  in  2  readback select: 0 temp, 1 light, 2 alarm_delay, 3 dev_mask.
- `rd_data`  out  8  registered readback of the selected committed field.

## Operation

- FSM states: IDLE, CHECK, COMMIT, REJECT.
- Write trigger is the rising edge of `write_en`, detected against a registered sample `we_q`.
  - `we_q` resets to 1. A `write_en` held high through reset therefore triggers no write; it must go low first.
- IDLE: on a trigger, `shadow <= configin`, `busy <= 1`, go to CHECK.
- CHECK: the shadow word is valid iff all of the following hold. Go to COMMIT if valid, else REJECT.
  - TEMP_MIN <= temp <= TEMP_MAX (unsigned).
  - light <= LIGHT_MAX.
  - alarm_delay != 0.
- COMMIT: perform the following, then go to IDLE with `busy <= 0`.
  - Load the four field registers from shadow.
  - If key_change = 1, `syskey <= new_key`.
  - `write_done <= 1` for one cycle.
  - `write_count` += 1, saturating at 255.
- REJECT: `write_err <= 1` for one cycle; committed fields, `syskey` and `write_count` are unchanged. Go to IDLE with `busy <= 0`.
- A `write_en` edge while not in IDLE is ignored and not queued. `configin` changes after capture do not affect the shadow.
- `rd_data` <= field[`rd_sel`] every cycle. It reflects the committed value one cycle after the commit edge.
- Reset (at any time, including mid-operation), asynchronous:
  - Shadow is discarded and the FSM returns to IDLE.
  - `syskey` = 2'b00, `temp_set` = 8'd22, `light_lvl` = 0, `alarm_delay` = 8'd30, `dev_mask` = 0.
  - `busy`, `write_done`, `write_err`, `write_count`, `rd_data` = 0.

## Timing

- Edge N samples `write_en` = 1 with `we_q` = 0: capture; `busy` is high after N.
- Edge N+1: CHECK resolves.
- Edge N+2: fields and `syskey` update; `write_done` or `write_err` is high for exactly the N+2 to N+3 cycle; `busy` falls.
- Edge N+3: `rd_data` shows the new field.
- Trigger-to-commit latency is 2 cycles. The minimum spacing between accepted writes is 3 cycles, because `write_en` must also fall and rise again.
- `write_done` and `write_err` are never high together. `busy` is high for exactly 2 cycles per accepted write.

## Test plan

- Reset with `write_en` = 1 held high: no write occurs; outputs hold reset values (temp 22, delay 30, `syskey` 00). Dropping and re-raising `write_en` then triggers a write.
- Valid write, temp 25, light 50, delay 10, mask 8'hA5, key_change 0: `write_done` pulses at N+2; fields update; `syskey` stays 00; `write_count` = 1; `rd_sel` = 3 gives `rd_data` = 8'hA5 at N+3.
- Write with key_change 1, new_key 2'b10: `syskey` = 10 after N+2. Then a write with temp 40: `write_err` pulses, `syskey` stays 10, fields unchanged.
- Boundaries:
  - temp 10 and temp 35 are accepted; temp 9 and temp 36 are rejected.
  - light 100 is accepted; light 101 is rejected.
  - delay 0 is rejected.
- `write_en` held high for 10 cycles gives exactly one commit. Toggling `write_en` during CHECK is ignored; `busy` is high for 2 cycles only.
- Reset asserted at the N+1 edge: no `write_done`, all outputs at reset values. 256 valid writes leave `write_count` at 255.
